morse_encoder: RTL and testbench



---
 rtl/morse_encoder.sv | 180 ++++++++++++++++++
 tb/tb_morse_encoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/morse_encoder.sv
// ASCII-to-Morse keyer: accepts one character per valid/ready transfer and emits
// an on/off keyed mark/space signal with unit-based dot, dash and gap timing.
module morse_encoder #(
    parameter int unsigned UNIT_CYCLES = 12500000,
    parameter int unsigned UNIT_BITS   = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] letter,
    input  logic       letter_valid,
    output logic       letter_ready,
    output logic       signal,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_SGAP,
        S_LGAP,
        S_WGAP,
        S_ERR
    } state_t;

    localparam int unsigned LEN_W = 3;
    localparam int unsigned PAT_W = 5;

    // Returns {length, left-aligned pattern}; length 0 marks an unsupported code.
    function automatic logic [7:0] lookup(input logic [7:0] c);
        logic [7:0] r;
        case (c)
            8'h41: r = {3'd2, 5'b01000};  // A
            8'h42: r = {3'd4, 5'b10000};
            8'h43: r = {3'd4, 5'b10100};
            8'h44: r = {3'd3, 5'b10000};
            8'h45: r = {3'd1, 5'b00000};
            8'h46: r = {3'd4, 5'b00100};
            8'h47: r = {3'd3, 5'b11000};
            8'h48: r = {3'd4, 5'b00000};
            8'h49: r = {3'd2, 5'b00000};
            8'h4A: r = {3'd4, 5'b01110};
            8'h4B: r = {3'd3, 5'b10100};
            8'h4C: r = {3'd4, 5'b01000};
            8'h4D: r = {3'd2, 5'b11000};
            8'h4E: r = {3'd2, 5'b10000};
            8'h4F: r = {3'd3, 5'b11100};
            8'h50: r = {3'd4, 5'b01100};
            8'h51: r = {3'd4, 5'b11010};
            8'h52: r = {3'd3, 5'b01000};
            8'h53: r = {3'd3, 5'b00000};
            8'h54: r = {3'd1, 5'b10000};
            8'h55: r = {3'd3, 5'b00100};
            8'h56: r = {3'd4, 5'b00010};
            8'h57: r = {3'd3, 5'b01100};
            8'h58: r = {3'd4, 5'b10010};
            8'h59: r = {3'd4, 5'b10110};
            8'h5A: r = {3'd4, 5'b11000};  // Z
            8'h30: r = {3'd5, 5'b11111};  // 0
            8'h31: r = {3'd5, 5'b01111};
            8'h32: r = {3'd5, 5'b00111};
            8'h33: r = {3'd5, 5'b00011};
            8'h34: r = {3'd5, 5'b00001};
            8'h35: r = {3'd5, 5'b00000};
            8'h36: r = {3'd5, 5'b10000};
            8'h37: r = {3'd5, 5'b11000};
            8'h38: r = {3'd5, 5'b11100};
            8'h39: r = {3'd5, 5'b11110};  // 9
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    state_t               state;
    logic [UNIT_BITS-1:0] cnt;
    logic [1:0]           units_left;
    logic [LEN_W-1:0]     sym_left;
    logic [PAT_W-1:0]     pattern;

    logic [7:0]       upper_c;
    logic [7:0]       lut_c;
    logic [LEN_W-1:0] lut_len_c;
    logic [PAT_W-1:0] lut_pat_c;
    logic             is_space_c;
    logic             unit_end_c;

    assign upper_c    = (letter >= 8'h61 && letter <= 8'h7A) ? letter - 8'h20 : letter;
    assign lut_c      = lookup(upper_c);
    assign lut_len_c  = lut_c[7:5];
    assign lut_pat_c  = lut_c[4:0];
    assign is_space_c = (letter == 8'h20);
    assign unit_end_c = (cnt == UNIT_BITS'(UNIT_CYCLES - 1));

    // Timed states count whole units: cnt spans one unit, units_left the remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            units_left   <= 2'd0;
            sym_left     <= '0;
            pattern      <= '0;
            signal       <= 1'b0;
            busy         <= 1'b0;
            letter_ready <= 1'b1;
            err          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (letter_valid) begin
                        letter_ready <= 1'b0;
                        busy         <= 1'b1;
                        cnt          <= '0;
                        if (is_space_c) begin
                            state      <= S_WGAP;
                            units_left <= 2'd3;
                        end else if (lut_len_c != 3'd0) begin
                            state      <= S_MARK;
                            signal     <= 1'b1;
                            pattern    <= lut_pat_c;
                            sym_left   <= lut_len_c - 3'd1;
                            units_left <= lut_pat_c[4] ? 2'd2 : 2'd0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    state        <= S_IDLE;
                    err          <= 1'b0;
                    busy         <= 1'b0;
                    letter_ready <= 1'b1;
                end
                S_MARK, S_SGAP, S_LGAP, S_WGAP: begin
                    if (!unit_end_c) begin
                        cnt <= cnt + UNIT_BITS'(1);
                    end else begin
                        cnt <= '0;
                        if (units_left != 2'd0) begin
                            units_left <= units_left - 2'd1;
                        end else begin
                            case (state)
                                S_MARK: begin
                                    signal <= 1'b0;
                                    if (sym_left != 3'd0) begin
                                        state      <= S_SGAP;
                                        units_left <= 2'd0;
                                    end else begin
                                        state      <= S_LGAP;
                                        units_left <= 2'd2;
                                    end
                                end
                                S_SGAP: begin
                                    state      <= S_MARK;
                                    signal     <= 1'b1;
                                    pattern    <= pattern << 1;
                                    sym_left   <= sym_left - 3'd1;
                                    units_left <= pattern[3] ? 2'd2 : 2'd0;
                                end
                                default: begin
                                    state        <= S_IDLE;
                                    busy         <= 1'b0;
                                    letter_ready <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    signal       <= 1'b0;
                    busy         <= 1'b0;
                    letter_ready <= 1'b1;
                    err          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: directed and random characters compared cycle by cycle
// against a waveform built from Morse code strings.
module tb_morse_encoder;

    localparam int unsigned U = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] letter;
    logic       letter_valid;
    logic       letter_ready;
    logic       signal;
    logic       busy;
    logic       err;

    int checks   = 0;
    int failures = 0;
    int zero_run = 0;
    int last_run = 0;

    logic [3:0] exp_q[$];

    string tbl[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                       ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                       "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                       "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                       "--...", "---..", "----."};

    morse_encoder #(.UNIT_CYCLES(U), .UNIT_BITS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .letter       (letter),
        .letter_valid (letter_valid),
        .letter_ready (letter_ready),
        .signal       (signal),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic string code_of(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        if (u >= 8'h41 && u <= 8'h5A) return tbl[int'(u) - 65];
        if (u >= 8'h30 && u <= 8'h39) return tbl[26 + int'(u) - 48];
        return "";
    endfunction

    // Expected per-cycle {signal, busy, letter_ready, err} from transfer to next idle.
    task automatic push_n(input int n, input logic [3:0] t);
        for (int i = 0; i < n; i++) exp_q.push_back(t);
    endtask

    task automatic build(input logic [7:0] c);
        string m;
        exp_q.delete();
        m = code_of(c);
        if (c == 8'h20) begin
            push_n(4 * U, 4'b0100);
        end else if (m.len() == 0) begin
            push_n(1, 4'b0101);
        end else begin
            for (int i = 0; i < m.len(); i++) begin
                push_n((m[i] == "-") ? 3 * U : U, 4'b1100);
                if (i != m.len() - 1) push_n(U, 4'b0100);
            end
            push_n(3 * U, 4'b0100);
        end
        push_n(1, 4'b0010);
    endtask

    task automatic sample(input string tag, input logic [3:0] expv);
        logic [3:0] obs;
        obs = {signal, busy, letter_ready, err};
        if (signal === 1'b1) begin
            if (zero_run != 0) last_run = zero_run;
            zero_run = 0;
        end else begin
            zero_run++;
        end
        check(tag, 32'(obs), 32'(expv));
    endtask

    // Call in an idle cycle (after posedge): transfer on the next edge, then
    // track the whole character while a junk letter stays valid.
    task automatic send(input logic [7:0] c);
        string tag;
        build(c);
        tag = $sformatf("wave_ch%02h", c);
        letter       = c;
        letter_valid = 1'b1;
        @(posedge clk);
        #1;
        letter = 8'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            sample(tag, exp_q[i]);
            if (i != exp_q.size() - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    logic [7:0] rnd_ch;

    initial begin
        rst_n        = 1'b0;
        letter       = 8'h00;
        letter_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sample("reset_state", 4'b0010);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sample("idle_after_reset", 4'b0010);

        send(8'h45);                 // E
        send(8'h41);                 // A then a back-to-back
        send(8'h61);
        send(8'h30);                 // 0
        send(8'h23);                 // unsupported
        send(8'h54);                 // T
        send(8'h45);                 // E, space, E
        send(8'h20);
        send(8'h45);
        check("word_gap_low_cycles", 32'(last_run), 32'(3 * U + 1 + 4 * U + 1));

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: rnd_ch = 8'(8'h41 + $urandom_range(0, 25)) |
                                           ($urandom_range(0, 1) != 0 ? 8'h20 : 8'h00);
                6, 7:    rnd_ch = 8'(8'h30 + $urandom_range(0, 9));
                8:       rnd_ch = 8'h20;
                default: rnd_ch = 8'($urandom_range(0, 255));
            endcase
            send(rnd_ch);
        end

        // Reset during the dash of N: drops asynchronously, nothing afterwards.
        letter       = 8'h4E;
        letter_valid = 1'b1;
        @(posedge clk);
        #1;
        letter_valid = 1'b0;
        repeat (2 * U + 2) @(posedge clk);
        #1;
        check("n_dash_active", 32'(signal), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_drop_signal", 32'(signal), 32'd0);
        sample("async_reset_state", 4'b0010);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            sample("post_reset_quiet", 4'b0010);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
